// File: rtl/serial_sub.sv
// Multi-cycle unsigned subtractor: DIGIT bits per clock, LSB first, registered borrow chain.
// Optional build macro SERIAL_SUB_SAT_EN clamps a negative result to zero.
module serial_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("serial_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              brw_q, brw_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;

    logic [DIGIT-1:0]       dig;
    logic                   dig_bout;
    logic [WIDTH+DIGIT-1:0] res_full;
    logic [WIDTH-1:0]       res_next;
    logic [WIDTH-1:0]       diff_final;

    // Full-subtractor ripple across one digit; bit 0 borrows in from the register.
    always_comb begin
        logic c;
        logic ai;
        logic bi;
        dig = '0;
        c   = brw_q;
        for (int i = 0; i < DIGIT; i++) begin
            ai     = a_q[i];
            bi     = b_q[i];
            dig[i] = ai ^ bi ^ c;
            c      = (~ai & bi) | (~(ai ^ bi) & c);
        end
        dig_bout = c;
    end

    // New digit enters at the MSB side so the register is in order after the last shift.
    always_comb begin
        res_full = {dig, res_q} >> DIGIT;
        res_next = res_full[WIDTH-1:0];
    end

`ifdef SERIAL_SUB_SAT_EN
    assign diff_final = dig_bout ? '0 : res_next;
`else
    assign diff_final = res_next;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = res_next;
                brw_d = dig_bout;
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d   = diff_final;
                    borrow_d = dig_bout;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

endmodule
